// File: rtl/seven_segment_pkg.sv
// Shared constants for 7-segment display blocks: segment encodings of the
// decimal digits (a..g, MSB = a, 1 = lit), the invalid BCD code and the
// sampler state encoding.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } samplerState_t;

endpackage

// File: rtl/seven_segment_to_bcd.sv
// Combinational 7-segment to BCD decoder. Any pattern that is not one of the
// ten decimal digits (blank included) yields BCD_INVALID with illegal set.
module seven_segment_to_bcd
    import seven_segment_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       illegal
);

    // Table lookup; defaults cover every non-digit pattern.
    always_comb begin
        bcd     = BCD_INVALID;
        illegal = 1'b1;
        case (seg)
            SEG_0: begin bcd = 4'd0; illegal = 1'b0; end
            SEG_1: begin bcd = 4'd1; illegal = 1'b0; end
            SEG_2: begin bcd = 4'd2; illegal = 1'b0; end
            SEG_3: begin bcd = 4'd3; illegal = 1'b0; end
            SEG_4: begin bcd = 4'd4; illegal = 1'b0; end
            SEG_5: begin bcd = 4'd5; illegal = 1'b0; end
            SEG_6: begin bcd = 4'd6; illegal = 1'b0; end
            SEG_7: begin bcd = 4'd7; illegal = 1'b0; end
            SEG_8: begin bcd = 4'd8; illegal = 1'b0; end
            SEG_9: begin bcd = 4'd9; illegal = 1'b0; end
            default: begin
                bcd     = BCD_INVALID;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Receive side of a multiplexed 7-segment display. Synchronises the segment,
// decimal-point and digit-enable lines, captures each digit once its pattern
// has been stable for STABLE_CYCLES samples, and hands out complete frames of
// NDIG digits on a valid/ready interface.
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter  int NDIG          = 4,
    parameter  int STABLE_CYCLES = 16,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_in,
    input  logic                dp_in,
    input  logic [NDIG-1:0]     dig_en,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic [NDIG-1:0]     dp_out,
    output logic [NDIG-1:0]     err_out,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                overrun,
    output logic                locked
);

    localparam int SMP_W = NDIG + 8;

    // Sample vector layout: {dig_en, dp, seg}
    logic [SMP_W-1:0] syncMeta;
    logic [SMP_W-1:0] smp;
    logic [SMP_W-1:0] prev;

    logic [6:0]      smpSeg;
    logic            smpDp;
    logic [NDIG-1:0] smpDig;
    logic            digOneHot;
    logic            changed;

    samplerState_t   state;
    samplerState_t   stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic            capture;

    logic [3:0]      decBcd;
    logic            decIllegal;

    logic [4*NDIG-1:0] digitBus;
    logic [NDIG-1:0]   dpReg;
    logic [NDIG-1:0]   errReg;
    logic [NDIG-1:0]   mask;
    logic [NDIG-1:0]   maskNext;

    logic            frameDone;
    logic            loadFrame;
    logic            dropFrame;
    logic            transfer;

    // Two-flop synchroniser per input bit, plus one-cycle history for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta <= '0;
            smp      <= '0;
            prev     <= '0;
        end else begin
            syncMeta <= {dig_en, dp_in, seg_in};
            smp      <= syncMeta;
            prev     <= smp;
        end
    end

    assign smpSeg    = smp[6:0];
    assign smpDp     = smp[7];
    assign smpDig    = smp[SMP_W-1:8];
    assign digOneHot = $onehot(smpDig);
    assign changed   = (smp != prev);

    seven_segment_to_bcd uDecoder (
        .seg     (smpSeg),
        .bcd     (decBcd),
        .illegal (decIllegal)
    );

    // Sampler state and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Sampler next state: a digit is captured on the edge where the counter
    // would reach STABLE_CYCLES-1, i.e. after STABLE_CYCLES identical samples.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                cntNext = '0;
                if (digOneHot) begin
                    stateNext = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!digOneHot) begin
                    stateNext = ST_IDLE;
                    cntNext   = '0;
                end else if (changed) begin
                    cntNext = '0;
                end else if (cnt == CNT_W'(STABLE_CYCLES - 2)) begin
                    capture   = 1'b1;
                    cntNext   = CNT_W'(STABLE_CYCLES - 1);
                    stateNext = ST_LOCKED;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (!digOneHot) begin
                    stateNext = ST_IDLE;
                    cntNext   = '0;
                end else if (changed) begin
                    stateNext = ST_SETTLE;
                    cntNext   = '0;
                end
            end
            default: begin
                stateNext = ST_IDLE;
                cntNext   = '0;
            end
        endcase
    end

    assign locked = (state == ST_LOCKED);

    // Per-digit capture registers, written at the one-hot position of dig_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digitBus <= '0;
            dpReg    <= '0;
            errReg   <= '0;
        end else if (capture) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (smpDig[i]) begin
                    digitBus[4*i +: 4] <= decBcd;
                    dpReg[i]           <= smpDp;
                    errReg[i]          <= decIllegal;
                end
            end
        end
    end

    assign frameDone = &mask;
    assign transfer  = frame_valid && frame_ready;
    assign loadFrame = frameDone && (!frame_valid || frame_ready);
    assign dropFrame = frameDone && frame_valid && !frame_ready;

    // A capture in the completion cycle belongs to the next frame, so it is
    // OR-ed in after the completed mask is cleared.
    always_comb begin
        maskNext = mask;
        if (frameDone) begin
            maskNext = '0;
        end
        if (capture) begin
            maskNext = maskNext | smpDig;
        end
    end

    // Capture mask tracking which digits of the current frame are present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else begin
            mask <= maskNext;
        end
    end

    // Frame output registers, handshake and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out     <= '0;
            dp_out      <= '0;
            err_out     <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (loadFrame) begin
                bcd_out     <= digitBus;
                dp_out      <= dpReg;
                err_out     <= errReg;
                frame_valid <= 1'b1;
            end else if (transfer) begin
                frame_valid <= 1'b0;
            end
            if (dropFrame) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
